// File: rtl/if_id_skid_pkg.sv
// Shared constants for the IF->ID pipeline register with skid buffer.
package if_id_skid_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int INST_W_DEF = 32;

  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;

  localparam logic RST_ACT = 1'b0;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

endpackage

// File: rtl/if_id_skid_pipe_payload_reg.sv
// Width-parametrised payload register with load enable and clear.
module pipe_payload_reg
  import if_id_skid_pkg::*;
#(
  parameter int           W       = 64,
  parameter logic [W-1:0] CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst == RST_ACT) begin
      q <= CLR_VAL;
    end else if (clr) begin
      q <= CLR_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/if_id_skid.sv
// IF->ID stage: valid/ready handshake, flush bubbles, optional skid.
module if_id_skid
  import if_id_skid_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                INST_W   = INST_W_DEF,
  parameter bit                SKID_EN  = 1'b1,
  parameter logic [INST_W-1:0] NOP_INST = NOP_INST_DEF[INST_W-1:0]
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic [INST_W-1:0] if_inst,
  input  logic              flush,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic [1:0]        occupancy
);

  localparam int PW = ADDR_W + INST_W;
  localparam logic [PW-1:0] BUBBLE = {{ADDR_W{1'b0}}, NOP_INST};

  logic [1:0]    st;
  logic [1:0]    st_n;
  logic          rdy_q;
  logic          accept;
  logic          drain;
  logic          m_ld;
  logic          m_clr;
  logic          m_from_s;
  logic          s_ld;
  logic [PW-1:0] in_pl;
  logic [PW-1:0] m_d;
  logic [PW-1:0] m_q;
  logic [PW-1:0] s_q;

  assign in_pl  = {if_pc, if_inst};
  assign accept = if_valid & if_ready;
  assign drain  = id_valid & id_ready;

  always_comb begin
    st_n     = st;
    m_ld     = 1'b0;
    m_clr    = 1'b0;
    m_from_s = 1'b0;
    s_ld     = 1'b0;
    if (flush) begin
      st_n  = ST_EMPTY;
      m_clr = 1'b1;
    end else begin
      unique case (st)
        ST_EMPTY: begin
          if (accept) begin
            st_n = ST_ONE;
            m_ld = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            m_ld = 1'b1;
          end else if (accept) begin
            st_n = ST_TWO;
            s_ld = 1'b1;
          end else if (drain) begin
            st_n  = ST_EMPTY;
            m_clr = 1'b1;
          end
        end
        ST_TWO: begin
          if (drain) begin
            st_n     = ST_ONE;
            m_ld     = 1'b1;
            m_from_s = 1'b1;
          end
        end
        default: begin
          st_n  = ST_EMPTY;
          m_clr = 1'b1;
        end
      endcase
    end
  end

  // if_ready in skid mode is a flop tracking whether the next state is full
  always_ff @(posedge clk) begin
    if (rst == RST_ACT) begin
      st    <= ST_EMPTY;
      rdy_q <= 1'b1;
    end else begin
      st    <= st_n;
      rdy_q <= (st_n != ST_TWO);
    end
  end

  assign m_d = m_from_s ? s_q : in_pl;

  pipe_payload_reg #(
    .W       (PW),
    .CLR_VAL (BUBBLE)
  ) u_main (
    .clk (clk),
    .rst (rst),
    .en  (m_ld),
    .clr (m_clr),
    .d   (m_d),
    .q   (m_q)
  );

  generate
    if (SKID_EN) begin : g_skid
      pipe_payload_reg #(
        .W       (PW),
        .CLR_VAL (BUBBLE)
      ) u_skid (
        .clk (clk),
        .rst (rst),
        .en  (s_ld),
        .clr (1'b0),
        .d   (in_pl),
        .q   (s_q)
      );
      assign if_ready = rdy_q;
    end else begin : g_noskid
      assign s_q      = BUBBLE;
      assign if_ready = ~id_valid | id_ready;
    end
  endgenerate

  assign id_valid  = (st != ST_EMPTY);
  assign id_pc     = m_q[PW-1:INST_W];
  assign id_inst   = m_q[INST_W-1:0];
  assign occupancy = st;

endmodule

// File: tb/tb_if_id_skid.sv
// Self-checking bench: directed table, hand sequences, random vs queue model.
module tb_if_id_skid;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        flush;
  logic        id_ready;

  logic        if_ready1, id_valid1;
  logic [31:0] id_pc1, id_inst1;
  logic [1:0]  occ1;
  logic        if_ready0, id_valid0;
  logic [31:0] id_pc0, id_inst0;
  logic [1:0]  occ0;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  if_id_skid #(.SKID_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready1),
    .if_pc(if_pc), .if_inst(if_inst), .flush(flush),
    .id_valid(id_valid1), .id_ready(id_ready), .id_pc(id_pc1),
    .id_inst(id_inst1), .occupancy(occ1)
  );

  if_id_skid #(.SKID_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready0),
    .if_pc(if_pc), .if_inst(if_inst), .flush(flush),
    .id_valid(id_valid0), .id_ready(id_ready), .id_pc(id_pc0),
    .id_inst(id_inst0), .occupancy(occ0)
  );

  function automatic logic [31:0] mk_inst(logic [31:0] pc);
    return pc + 32'h0000_0013;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a FIFO of {pc,inst} with capacity 2 (skid) or 1 (plain)
  logic [63:0] q1[$];
  logic [63:0] q0[$];
  bit model_ok = 0;

  task automatic check_model();
    logic [63:0] h1, h0;
    if (!model_ok) return;
    h1 = (q1.size() > 0) ? q1[0] : 64'h0;
    h0 = (q0.size() > 0) ? q0[0] : 64'h0;
    chk("m1_valid", 64'(id_valid1), 64'(q1.size() > 0));
    chk("m1_payload", {id_pc1, id_inst1}, h1);
    chk("m1_occ", 64'(occ1), 64'(q1.size()));
    chk("m1_if_ready", 64'(if_ready1), 64'(q1.size() < 2));
    chk("m0_valid", 64'(id_valid0), 64'(q0.size() > 0));
    chk("m0_payload", {id_pc0, id_inst0}, h0);
    chk("m0_occ", 64'(occ0), 64'(q0.size()));
    chk("m0_if_ready", 64'(if_ready0),
        64'(q0.size() == 0 || id_ready));
  endtask

  task automatic step();
    bit a1, d1, a0, d0, r, f;
    logic [63:0] in;
    #1;
    check_model();
    r  = rst;
    f  = flush;
    in = {if_pc, if_inst};
    a1 = if_valid && (q1.size() < 2);
    d1 = id_ready && (q1.size() > 0);
    a0 = if_valid && (q0.size() == 0 || id_ready);
    d0 = id_ready && (q0.size() > 0);
    @(posedge clk);
    #1;
    if (!r) begin
      q1.delete(); q0.delete(); model_ok = 1;
    end else if (f) begin
      q1.delete(); q0.delete();
    end else begin
      if (d1) void'(q1.pop_front());
      if (a1) q1.push_back(in);
      if (d0) void'(q0.pop_front());
      if (a0) q0.push_back(in);
    end
  endtask

  task automatic drive(bit r, bit f, bit v, logic [31:0] pc, bit rdy);
    rst      = r;
    flush    = f;
    if_valid = v;
    if_pc    = pc;
    if_inst  = mk_inst(pc);
    id_ready = rdy;
  endtask

  typedef struct {
    bit          rst;
    bit          flush;
    bit          v;
    logic [31:0] pc;
    bit          rdy;
    bit          e_v;
    logic [31:0] e_pc;
    logic [1:0]  e_occ;
    bit          e_ifr;
  } vec_t;

  vec_t tv[20];

  initial begin
    logic [31:0] e_inst;
    tv[0]  = '{0,0,1,32'h100,1, 0,32'h0,  2'd0,1};
    tv[1]  = '{0,0,1,32'h100,1, 0,32'h0,  2'd0,1};
    tv[2]  = '{1,0,0,32'h0,  1, 0,32'h0,  2'd0,1};
    tv[3]  = '{1,0,1,32'h100,1, 1,32'h100,2'd1,1};
    tv[4]  = '{1,0,1,32'h104,1, 1,32'h104,2'd1,1};
    tv[5]  = '{1,0,1,32'h108,1, 1,32'h108,2'd1,1};
    tv[6]  = '{1,0,0,32'h0,  1, 0,32'h0,  2'd0,1};
    tv[7]  = '{1,0,1,32'h100,1, 1,32'h100,2'd1,1};
    tv[8]  = '{1,0,1,32'h104,0, 1,32'h100,2'd2,0};
    tv[9]  = '{1,0,1,32'h108,0, 1,32'h100,2'd2,0};
    tv[10] = '{1,0,0,32'h0,  1, 1,32'h104,2'd1,1};
    tv[11] = '{1,0,0,32'h0,  1, 0,32'h0,  2'd0,1};
    tv[12] = '{1,0,1,32'h200,0, 1,32'h200,2'd1,1};
    tv[13] = '{1,0,1,32'h204,0, 1,32'h200,2'd2,0};
    tv[14] = '{1,1,1,32'h208,0, 0,32'h0,  2'd0,1};
    tv[15] = '{1,0,0,32'h0,  1, 0,32'h0,  2'd0,1};
    tv[16] = '{1,0,1,32'h400,0, 1,32'h400,2'd1,1};
    tv[17] = '{1,0,1,32'h404,0, 1,32'h400,2'd2,0};
    tv[18] = '{0,0,0,32'h0,  1, 0,32'h0,  2'd0,1};
    tv[19] = '{1,0,0,32'h0,  1, 0,32'h0,  2'd0,1};

    drive(0, 0, 0, 32'h0, 0);
    for (int i = 0; i < 20; i++) begin
      drive(tv[i].rst, tv[i].flush, tv[i].v, tv[i].pc, tv[i].rdy);
      step();
      e_inst = tv[i].e_v ? mk_inst(tv[i].e_pc) : 32'h0;
      chk($sformatf("t%0d_valid", i), 64'(id_valid1), 64'(tv[i].e_v));
      chk($sformatf("t%0d_pc", i), 64'(id_pc1), 64'(tv[i].e_pc));
      chk($sformatf("t%0d_inst", i), 64'(id_inst1), 64'(e_inst));
      chk($sformatf("t%0d_occ", i), 64'(occ1), 64'(tv[i].e_occ));
      chk($sformatf("t%0d_if_ready", i), 64'(if_ready1), 64'(tv[i].e_ifr));
    end

    // Plain register: combinational back-pressure, then accept+drain
    drive(1, 0, 1, 32'h300, 0);
    step();
    chk("nsk_hold_valid", 64'(id_valid0), 64'd1);
    chk("nsk_hold_pc", 64'(id_pc0), 64'h300);
    drive(1, 0, 0, 32'h0, 0);
    #1;
    chk("nsk_stall_if_ready", 64'(if_ready0), 64'd0);
    drive(1, 0, 1, 32'h304, 1);
    #1;
    chk("nsk_go_if_ready", 64'(if_ready0), 64'd1);
    step();
    chk("nsk_next_pc", 64'(id_pc0), 64'h304);
    chk("nsk_next_inst", 64'(id_inst0), 64'(mk_inst(32'h304)));
    chk("nsk_occ", 64'(occ0), 64'd1);

    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 49) != 0),
            ($urandom_range(0, 19) == 0),
            $urandom_range(0, 3) != 0,
            $urandom,
            $urandom_range(0, 2) != 0);
      step();
    end

    drive(1, 0, 0, 32'h0, 1);
    step();
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
